// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcode and controller state encodings
package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_ADD  = 3'b010,
    OP_SLTU = 3'b011,
    OP_XOR  = 3'b100,
    OP_MUL  = 3'b101,
    OP_SUB  = 3'b110,
    OP_SLT  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_mc_mul.sv
// rtl/alu_mc_mul.sv - iterative unsigned shift-add multiplier, one multiplier bit per cycle
module alu_mc_mul #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic [DATA_WIDTH-1:0]     a_i,
  input  logic [DATA_WIDTH-1:0]     b_i,
  output logic                      done_o,
  output logic [2*DATA_WIDTH-1:0]   product_o
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;

  logic [2*DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0]   mcand_q;
  logic [CW-1:0]           cnt_q;
  logic                    busy_q;
  logic                    done_q;

  // acc holds {partial high word, remaining multiplier bits}; each step adds and shifts right
  function automatic logic [2*DATA_WIDTH-1:0] mul_step(
    input logic [2*DATA_WIDTH-1:0] acc,
    input logic [DATA_WIDTH-1:0]   mcand
  );
    logic [DATA_WIDTH:0] sum;
    sum = {1'b0, acc[2*DATA_WIDTH-1:DATA_WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    return {sum, acc[DATA_WIDTH-1:1]};
  endfunction

  // the first step runs on the start edge straight from the operand inputs
  always_comb begin
    acc_d = mul_step(acc_q, mcand_q);
    if (start_i) begin
      acc_d = mul_step({{DATA_WIDTH{1'b0}}, b_i}, a_i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q   <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (start_i) begin
      acc_q   <= acc_d;
      mcand_q <= a_i;
      cnt_q   <= CW'(1);
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else if (busy_q) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + CW'(1);
      if (cnt_q == CW'(DATA_WIDTH - 1)) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign done_o    = done_q;
  assign product_o = acc_q;

endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with valid/ready handshake and iterative MUL
module alu_mc
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [2:0]            ALUop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Result,
  output logic [DATA_WIDTH-1:0] Result_hi,
  output logic                  Overflow,
  output logic                  CarryOut,
  output logic                  Zero
);

  alu_state_e              state_q;
  logic [DATA_WIDTH-1:0]   result_q, result_hi_q;
  logic                    ovf_q, carry_q, zero_q;

  alu_op_e                 op;
  logic                    accept;
  logic                    mul_start;
  logic                    mul_done;
  logic [2*DATA_WIDTH-1:0] mul_product;
  logic [DATA_WIDTH-1:0]   mul_lo, mul_hi;

  logic [DATA_WIDTH:0]     sum, diff;
  logic                    borrow, add_ovf, sub_ovf;
  logic [DATA_WIDTH-1:0]   res_d;
  logic                    ovf_d, carry_d;

  assign op        = alu_op_e'(ALUop);
  assign accept    = in_valid && (state_q == ST_IDLE);
  assign mul_start = accept && (op == OP_MUL);
  assign mul_lo    = mul_product[DATA_WIDTH-1:0];
  assign mul_hi    = mul_product[2*DATA_WIDTH-1:DATA_WIDTH];

  alu_mc_mul #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mul (
    .clk      (clk),
    .rst      (rst),
    .start_i  (mul_start),
    .a_i      (A),
    .b_i      (B),
    .done_o   (mul_done),
    .product_o(mul_product)
  );

  // one subtractor serves SUB, SLT and SLTU; no carry out of A + ~B + 1 means A < B unsigned
  always_comb begin
    sum     = {1'b0, A} + {1'b0, B};
    diff    = {1'b0, A} + {1'b0, ~B} + {{DATA_WIDTH{1'b0}}, 1'b1};
    borrow  = ~diff[DATA_WIDTH];
    add_ovf = (A[DATA_WIDTH-1] == B[DATA_WIDTH-1]) && (sum[DATA_WIDTH-1] != A[DATA_WIDTH-1]);
    sub_ovf = (A[DATA_WIDTH-1] != B[DATA_WIDTH-1]) && (diff[DATA_WIDTH-1] != A[DATA_WIDTH-1]);
    res_d   = '0;
    ovf_d   = 1'b0;
    carry_d = 1'b0;
    case (op)
      OP_AND:  res_d = A & B;
      OP_OR:   res_d = A | B;
      OP_XOR:  res_d = A ^ B;
      OP_ADD: begin
        res_d   = sum[DATA_WIDTH-1:0];
        carry_d = sum[DATA_WIDTH];
        ovf_d   = add_ovf;
      end
      OP_SUB: begin
        res_d   = diff[DATA_WIDTH-1:0];
        carry_d = borrow;
        ovf_d   = sub_ovf;
      end
      OP_SLTU: begin
        res_d   = {{(DATA_WIDTH-1){1'b0}}, borrow};
        carry_d = borrow;
      end
      OP_SLT: begin
        res_d   = {{(DATA_WIDTH-1){1'b0}}, diff[DATA_WIDTH-1] ^ sub_ovf};
        carry_d = borrow;
        ovf_d   = sub_ovf;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      result_hi_q <= '0;
      ovf_q       <= 1'b0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            if (op == OP_MUL) begin
              state_q <= ST_MUL;
            end else begin
              state_q     <= ST_DONE;
              result_q    <= res_d;
              result_hi_q <= '0;
              ovf_q       <= ovf_d;
              carry_q     <= carry_d;
              zero_q      <= (res_d == '0);
            end
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            state_q     <= ST_DONE;
            result_q    <= mul_lo;
            result_hi_q <= mul_hi;
            ovf_q       <= 1'b0;
            carry_q     <= |mul_hi;
            zero_q      <= (mul_lo == '0);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign Result    = result_q;
  assign Result_hi = result_hi_q;
  assign Overflow  = ovf_q;
  assign CarryOut  = carry_q;
  assign Zero      = zero_q;

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - self-checking bench for alu_mc with a transaction-level reference model
module tb_alu_mc;

  localparam logic [2:0] OP_AND = 3'b000, OP_OR = 3'b001, OP_ADD = 3'b010, OP_SLTU = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100, OP_MUL = 3'b101, OP_SUB = 3'b110, OP_SLT = 3'b111;

  logic        clk, rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] A, B, Result, Result_hi;
  logic [2:0]  ALUop;
  logic        Overflow, CarryOut, Zero;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  A8, B8, Result8, Result_hi8;
  logic [2:0]  ALUop8;
  logic        Overflow8, CarryOut8, Zero8;

  int vectors = 0;
  int miscompares = 0;

  alu_mc #(.DATA_WIDTH(32)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B), .ALUop(ALUop),
    .out_valid(out_valid), .out_ready(out_ready), .Result(Result), .Result_hi(Result_hi),
    .Overflow(Overflow), .CarryOut(CarryOut), .Zero(Zero)
  );

  alu_mc #(.DATA_WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .A(A8), .B(B8), .ALUop(ALUop8),
    .out_valid(out_valid8), .out_ready(out_ready8), .Result(Result8), .Result_hi(Result_hi8),
    .Overflow(Overflow8), .CarryOut(CarryOut8), .Zero(Zero8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void ref_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                                 output logic [31:0] lo, output logic [31:0] hi,
                                 output logic ov, output logic cy, output logic z);
    longint sa, sb, s;
    longint unsigned ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    lo = '0; hi = '0; ov = 1'b0; cy = 1'b0;
    case (op)
      OP_AND: lo = a & b;
      OP_OR:  lo = a | b;
      OP_XOR: lo = a ^ b;
      OP_ADD: begin p = ua + ub; lo = p[31:0]; cy = p[32]; s = sa + sb; ov = (s != longint'(int'(s))); end
      OP_SUB: begin lo = a - b; cy = (ua < ub); s = sa - sb; ov = (s != longint'(int'(s))); end
      OP_SLTU: begin lo = {31'b0, ua < ub}; cy = (ua < ub); end
      OP_SLT: begin lo = {31'b0, sa < sb}; cy = (ua < ub); s = sa - sb; ov = (s != longint'(int'(s))); end
      OP_MUL: begin p = ua * ub; lo = p[31:0]; hi = p[63:32]; cy = (hi != 0); end
      default: ;
    endcase
    z = (lo == 0);
  endfunction

  // model: busy counts down the result latency, valid holds until the consumer takes it
  bit          m_started = 0;
  bit          m_busy = 0, m_valid = 0;
  int          m_wait = 0;
  logic [31:0] m_lo = 0, m_hi = 0, p_lo, p_hi;
  logic        m_ov = 0, m_cy = 0, m_z = 0, p_ov, p_cy, p_z;

  always @(posedge clk) begin
    if (!rst) begin
      m_started = 1;
      m_busy = 0; m_valid = 0;
      m_lo = 0; m_hi = 0; m_ov = 0; m_cy = 0; m_z = 0;
    end else if (m_started) begin
      if (m_valid) begin
        if (out_ready) m_valid = 0;
      end else if (m_busy) begin
        m_wait--;
        if (m_wait == 0) begin
          m_busy = 0; m_valid = 1;
          m_lo = p_lo; m_hi = p_hi; m_ov = p_ov; m_cy = p_cy; m_z = p_z;
        end
      end else if (in_valid) begin
        ref_op(A, B, ALUop, p_lo, p_hi, p_ov, p_cy, p_z);
        if (ALUop == OP_MUL) begin
          m_busy = 1; m_wait = 32;
        end else begin
          m_valid = 1;
          m_lo = p_lo; m_hi = p_hi; m_ov = p_ov; m_cy = p_cy; m_z = p_z;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [68:0] act, exp;
    if (m_started) begin
      act = {in_ready, out_valid, Result, Result_hi, Overflow, CarryOut, Zero};
      exp = {!m_busy && !m_valid, m_valid, m_lo, m_hi, m_ov, m_cy, m_z};
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("FAIL model_cycle t=%0t: rdy/vld/res/hi/ov/cy/z got %h expected %h", $time, act, exp);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    int n = 0;
    A = a; B = b; ALUop = op; in_valid = 1'b1;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    in_valid = 1'b0; A = $urandom; B = $urandom; ALUop = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
  endtask

  task automatic ack(input string name);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, "_idle_after_ack"}, {62'b0, in_ready, out_valid}, 64'h2);
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, output int lat);
    int n = 0;
    A8 = a; B8 = b; ALUop8 = op; in_valid8 = 1'b1;
    while (!in_ready8 && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    in_valid8 = 1'b0; A8 = 8'($urandom); B8 = 8'($urandom);
    lat = 1;
    while (!out_valid8 && lat < 100) begin @(negedge clk); lat++; end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    rst = 1'b0; in_valid = 1'b0; A = '0; B = '0; ALUop = '0; out_ready = 1'b0;
    in_valid8 = 1'b0; A8 = '0; B8 = '0; ALUop8 = '0; out_ready8 = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", {in_ready, out_valid, Result, Result_hi[29:0]}, {2'b10, 62'h0});
    chk("reset_flags", {61'b0, Overflow, CarryOut, Zero}, 64'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_release", {63'b0, in_ready}, 64'h1);

    issue(32'h7FFF_FFFF, 32'h1, OP_ADD);
    wait_valid(lat);
    chk("add_ovf_latency", lat, 1);
    chk("add_ovf_result", Result, 32'h8000_0000);
    chk("add_ovf_flags", {Overflow, CarryOut, Zero}, 3'b100);
    ack("add_ovf");

    issue(32'd5, 32'd5, OP_SUB);
    wait_valid(lat);
    chk("sub_eq_result", Result, 0);
    chk("sub_eq_flags", {Zero, CarryOut}, 2'b10);
    ack("sub_eq");

    issue(32'hFFFF_FFFF, 32'h1, OP_SLT);
    wait_valid(lat);
    chk("slt_neg_result", Result, 1);
    ack("slt");

    issue(32'hFFFF_FFFF, 32'h1, OP_SLTU);
    wait_valid(lat);
    chk("sltu_result", Result, 0);
    chk("sltu_zero", Zero, 1);
    ack("sltu");

    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_MUL);
    wait_valid(lat);
    chk("mul_latency", lat, 33);
    chk("mul_product", {Result_hi, Result}, 64'hFFFF_FFFE_0000_0001);
    chk("mul_carry", CarryOut, 1);
    ack("mul");

    issue(32'd10, 32'd20, OP_ADD);
    wait_valid(lat);
    in_valid = 1'b1; A = 32'h1; B = 32'h1; ALUop = OP_OR;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("backpressure_hold", {in_ready, out_valid, Result}, {32'b0, 2'b01, 32'd30});
    end
    in_valid = 1'b0;
    ack("backpressure");

    issue($urandom, $urandom, OP_MUL);
    repeat (11) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mul_abort_outputs", {out_valid, Result, Result_hi[30:0]}, 64'h0);
    chk("mul_abort_flags", {Overflow, CarryOut, Zero, in_ready}, 4'b0001);
    rst = 1'b1;
    @(negedge clk);
    chk("mul_abort_ready", in_ready, 1);
    repeat (40) @(negedge clk);
    issue(32'd2, 32'd3, OP_ADD);
    wait_valid(lat);
    chk("add_after_abort", Result, 5);
    ack("add_after_abort");

    issue8(8'hFF, 8'h01, OP_ADD, lat);
    chk("w8_add_latency", lat, 1);
    chk("w8_add", {Result8, CarryOut8, Zero8, Overflow8}, {8'h00, 3'b110});
    out_ready8 = 1'b1; @(negedge clk); out_ready8 = 1'b0;
    issue8(8'h10, 8'h10, OP_MUL, lat);
    chk("w8_mul_latency", lat, 9);
    chk("w8_mul", {Result_hi8, Result8, CarryOut8}, {8'h01, 8'h00, 1'b1});
    out_ready8 = 1'b1; @(negedge clk); out_ready8 = 1'b0;
    chk("w8_idle", {in_ready8, out_valid8}, 2'b10);

    for (int i = 0; i < 4000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      A         = pick();
      B         = pick();
      ALUop     = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 299) != 0);
      @(negedge clk);
    end
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
